if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL provide Clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL provide Reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide PCWrite, input, 1, hazard-unit PC update enable (1=update, 0=hold).
REQ-004 SHALL provide IF_ID_Write, input, 1, hazard-unit IF/ID load enable (1=load, 0=hold).
REQ-005 SHALL provide IF_ID_flush, input, 1, hazard-unit IF/ID squash request.
REQ-006 SHALL provide JumpReg, input, 1, with JumpRegTarget, input, 32, the register-indirect redirect.
REQ-007 SHALL provide Jump, input, 1, with JumpTarget, input, 32, the direct jump redirect.
REQ-008 SHALL provide Branch, input, 1, with BranchTarget, input, 32, the taken-branch redirect.
REQ-009 SHALL provide Instruction_in, input, 32, the instruction-memory read data for the current PC_out.
REQ-010 SHALL provide PC_out, output, 32, the current fetch address.
REQ-011 SHALL provide IF_ID_Instruction, output, 32, and IF_ID_PCPlus4, output, 32, the registered IF/ID contents.
REQ-012 SHALL provide IF_ID_Valid, output, 1, which is 1 when IF/ID holds a real instruction.
REQ-013 SHALL provide StallCount, output, 16, and FlushCount, output, 16, the saturating event counters.

Function
REQ-014 SHALL compute PCPlus4 = PC_out + 4 modulo 2^32, wrapping 0xFFFFFFFC to 0x00000000.
REQ-015 SHALL select next PC with priority JumpReg > Jump > Branch > PCPlus4.
REQ-016 SHALL force bits [1:0] of any selected redirect target to 00.
REQ-017 SHALL load next PC into PC_out at the clock edge only when PCWrite=1; with PCWrite=0, PC_out holds and redirects that cycle are dropped.
REQ-018 SHALL give IF/ID priority flush > write > hold at each edge.
REQ-019 On flush, SHALL set IF_ID_Instruction=0x00000000 (NOP), IF_ID_PCPlus4=0 and IF_ID_Valid=0.
REQ-020 On write without flush, SHALL set IF_ID_Instruction=Instruction_in, IF_ID_PCPlus4=PCPlus4 and IF_ID_Valid=1.
REQ-021 Otherwise, SHALL hold all IF/ID outputs unchanged.
REQ-022 SHALL apply flush even when IF_ID_Write=0, which is the hazard unit's jump/branch encoding.
REQ-023 SHALL treat PCWrite=0 with IF_ID_Write=1 as legal: IF/ID reloads the same PC's instruction.
REQ-024 SHALL increment StallCount on each edge with PCWrite=0, IF_ID_Write=0 and IF_ID_flush=0, saturating at 0xFFFF.
REQ-025 SHALL increment FlushCount on each edge with IF_ID_flush=1, saturating at 0xFFFF; a stall and a flush never count in the same cycle.
REQ-026 SHALL make outputs depend only on registered state, except PC_out, which is itself a register.

Reset
REQ-027 While Reset_n=0, SHALL hold PC_out=0, IF_ID_Instruction=0, IF_ID_PCPlus4=0, IF_ID_Valid=0, StallCount=0 and FlushCount=0, independent of Clk.
REQ-028 On a reset assertion mid-stall or mid-redirect, SHALL discard the pending redirect; the first fetch after release is from address 0.
REQ-029 SHALL perform the first update at the first rising edge with Reset_n=1.

Verification
REQ-030 Reset then 3 edges with PCWrite=IF_ID_Write=1 and Instruction_in=0x20080005: PC_out goes 0->4->8->C, IF_ID_PCPlus4=0xC and IF_ID_Valid=1.
REQ-031 PC=0x40 with Branch=1, BranchTarget=0x101, flush=1 and IF_ID_Write=0: next PC=0x100, IF/ID=NOP, Valid=0, FlushCount+1.
REQ-032 JumpReg=1 (0x200), Jump=1 (0x300) and Branch=1 (0x400) together with PCWrite=1: PC_out=0x200.
REQ-033 PCWrite=IF_ID_Write=flush=0 for 5 edges at PC=0x80: PC_out stays 0x80, IF/ID unchanged, StallCount=5.
REQ-034 StallCount preset to 0xFFFE by 2 stall edges: reads 0xFFFF and stays 0xFFFF on a third stall.
REQ-035 PC_out=0xFFFFFFFC with PCWrite=1: wraps to 0x00000000; Reset_n pulsed low between edges: all outputs 0 immediately.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage: program counter, next-PC selection and the
//   IF/ID pipeline register, plus saturating stall and flush counters.
//
// Ports
//   Clk, Reset_n                 rising-edge clock, async active-low reset
//   PCWrite                      1 = PC takes the selected next PC, 0 = hold
//   IF_ID_Write                  1 = IF/ID loads the fetched instruction
//   IF_ID_flush                  squash IF/ID to a NOP (wins over IF_ID_Write)
//   JumpReg/JumpRegTarget        register-indirect redirect (highest priority)
//   Jump/JumpTarget              direct jump redirect
//   Branch/BranchTarget          taken-branch redirect (lowest redirect priority)
//   Instruction_in               instruction memory data for PC_out
//   PC_out                       current fetch address
//   IF_ID_Instruction/PCPlus4    registered IF/ID contents
//   IF_ID_Valid                  IF/ID holds a real instruction
//   StallCount, FlushCount       saturating event counters
module if_fetch_stage (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        IF_ID_flush,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] Instruction_in,
    output logic [31:0] PC_out,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        stall;

    // Wraps naturally at 2^32.
    assign pc_plus4 = PC_out + 32'd4;

    // A stall is a full freeze; a flush cycle is never also counted as a stall.
    assign stall = !PCWrite && !IF_ID_Write && !IF_ID_flush;

    // Redirect targets are forced word-aligned.
    always_comb begin
        next_pc = pc_plus4;
        if (JumpReg)
            next_pc = {JumpRegTarget[31:2], 2'b00};
        else if (Jump)
            next_pc = {JumpTarget[31:2], 2'b00};
        else if (Branch)
            next_pc = {BranchTarget[31:2], 2'b00};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PC_out <= '0;
        end else if (PCWrite) begin
            PC_out <= next_pc;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            IF_ID_Instruction <= '0;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
        end else if (IF_ID_flush) begin
            IF_ID_Instruction <= '0;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
        end else if (IF_ID_Write) begin
            IF_ID_Instruction <= Instruction_in;
            IF_ID_PCPlus4     <= pc_plus4;
            IF_ID_Valid       <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall && StallCount != '1)
                StallCount <= StallCount + 16'd1;
            if (IF_ID_flush && FlushCount != '1)
                FlushCount <= FlushCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
//   Self-checking bench for if_fetch_stage: a behavioural reference model
//   compared against the DUT on every falling edge, plus directed scenarios
//   with hand-computed literal expectations.
module tb_if_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        PCWrite, IF_ID_Write, IF_ID_flush;
    logic        JumpReg, Jump, Branch;
    logic [31:0] JumpRegTarget, JumpTarget, BranchTarget, Instruction_in;
    logic [31:0] PC_out, IF_ID_Instruction, IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic [15:0] StallCount, FlushCount;

    int checks = 0;
    int errors = 0;

    if_fetch_stage dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .PCWrite          (PCWrite),
        .IF_ID_Write      (IF_ID_Write),
        .IF_ID_flush      (IF_ID_flush),
        .JumpReg          (JumpReg),
        .JumpRegTarget    (JumpRegTarget),
        .Jump             (Jump),
        .JumpTarget       (JumpTarget),
        .Branch           (Branch),
        .BranchTarget     (BranchTarget),
        .Instruction_in   (Instruction_in),
        .PC_out           (PC_out),
        .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_PCPlus4    (IF_ID_PCPlus4),
        .IF_ID_Valid      (IF_ID_Valid),
        .StallCount       (StallCount),
        .FlushCount       (FlushCount)
    );

    always #5 Clk = ~Clk;

    // Reference model: state of the fetch stage as described in plain terms.
    logic [31:0] m_pc, m_ins, m_pp4;
    logic        m_val;
    int          m_stall, m_flush;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_pc = 0; m_ins = 0; m_pp4 = 0; m_val = 0; m_stall = 0; m_flush = 0;
        end else begin
            logic [31:0] seq, tgt;
            seq = m_pc + 4;
            if (JumpReg)      tgt = JumpRegTarget & ~32'd3;
            else if (Jump)    tgt = JumpTarget & ~32'd3;
            else if (Branch)  tgt = BranchTarget & ~32'd3;
            else              tgt = seq;
            if (IF_ID_flush) begin
                m_ins = 0; m_pp4 = 0; m_val = 0;
                m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
            end else if (IF_ID_Write) begin
                m_ins = Instruction_in; m_pp4 = seq; m_val = 1;
            end else if (!PCWrite) begin
                m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            end
            if (PCWrite) m_pc = tgt;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge Clk) begin
        checks++;
        if (PC_out !== m_pc || IF_ID_Instruction !== m_ins || IF_ID_PCPlus4 !== m_pp4 ||
            IF_ID_Valid !== m_val || StallCount !== 16'(m_stall) || FlushCount !== 16'(m_flush)) begin
            errors++;
            $display("FAIL model t=%0t: dut pc=%h ins=%h pp4=%h v=%b st=%h fl=%h, model pc=%h ins=%h pp4=%h v=%b st=%h fl=%h",
                     $time, PC_out, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, StallCount, FlushCount,
                     m_pc, m_ins, m_pp4, m_val, 16'(m_stall), 16'(m_flush));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic pcw, input logic ifw, input logic fl,
                          input logic jr, input logic j, input logic br,
                          input logic [31:0] tgt, input logic [31:0] ins);
        PCWrite = pcw; IF_ID_Write = ifw; IF_ID_flush = fl;
        JumpReg = jr; Jump = j; Branch = br;
        JumpRegTarget = tgt; JumpTarget = tgt; BranchTarget = tgt;
        Instruction_in = ins;
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_pc"},    PC_out, 32'h0);
        chk({name, "_ins"},   IF_ID_Instruction, 32'h0);
        chk({name, "_pp4"},   IF_ID_PCPlus4, 32'h0);
        chk({name, "_valid"}, {31'b0, IF_ID_Valid}, 32'h0);
        chk({name, "_stall"}, {16'b0, StallCount}, 32'h0);
        chk({name, "_flush"}, {16'b0, FlushCount}, 32'h0);
    endtask

    initial begin
        Reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        edges(2);
        chk_all_zero("reset");
        Reset_n = 1'b1;

        // Three sequential fetches.
        set_in(1, 1, 0, 0, 0, 0, 32'h0, 32'h20080005);
        edges(1); chk("seq_pc1", PC_out, 32'h4);
        edges(1); chk("seq_pc2", PC_out, 32'h8);
        edges(1); chk("seq_pc3", PC_out, 32'hC);
        chk("seq_pp4", IF_ID_PCPlus4, 32'hC);
        chk("seq_ins", IF_ID_Instruction, 32'h20080005);
        chk("seq_valid", {31'b0, IF_ID_Valid}, 32'h1);

        // Jump to 0x40, then taken branch with flush and unaligned target.
        set_in(1, 1, 0, 0, 1, 0, 32'h40, 32'h11111111);
        edges(1); chk("jmp_pc", PC_out, 32'h40);
        set_in(1, 0, 1, 0, 0, 1, 32'h101, 32'h22222222);
        edges(1);
        chk("br_pc", PC_out, 32'h100);
        chk("br_ins", IF_ID_Instruction, 32'h0);
        chk("br_pp4", IF_ID_PCPlus4, 32'h0);
        chk("br_valid", {31'b0, IF_ID_Valid}, 32'h0);
        chk("br_flushcnt", {16'b0, FlushCount}, 32'h1);

        // Redirect priority: JumpReg beats Jump beats Branch.
        set_in(1, 1, 0, 1, 1, 1, 32'h0, 32'h33333333);
        JumpRegTarget = 32'h200; JumpTarget = 32'h300; BranchTarget = 32'h400;
        edges(1); chk("prio_pc", PC_out, 32'h200);
        set_in(1, 1, 0, 0, 1, 1, 32'h0, 32'h44444444);
        JumpTarget = 32'h300; BranchTarget = 32'h400;
        edges(1); chk("prio_j_pc", PC_out, 32'h300);

        // Land at 0x80 and stall 5 edges; the redirect on stall is dropped.
        set_in(1, 1, 0, 0, 1, 0, 32'h80, 32'hAAAA5555);
        edges(1);
        chk("pre_stall_pc", PC_out, 32'h80);
        chk("pre_stall_pp4", IF_ID_PCPlus4, 32'h304);
        set_in(0, 0, 0, 0, 1, 0, 32'h999, 32'h0);
        edges(5);
        chk("stall_pc", PC_out, 32'h80);
        chk("stall_ins", IF_ID_Instruction, 32'hAAAA5555);
        chk("stall_pp4", IF_ID_PCPlus4, 32'h304);
        chk("stall_cnt", {16'b0, StallCount}, 32'h5);

        // PC held while IF/ID reloads the same PC's instruction.
        set_in(0, 1, 0, 0, 0, 0, 32'h0, 32'h12345678);
        edges(1);
        chk("reload_pc", PC_out, 32'h80);
        chk("reload_ins", IF_ID_Instruction, 32'h12345678);
        chk("reload_pp4", IF_ID_PCPlus4, 32'h84);
        chk("reload_stall", {16'b0, StallCount}, 32'h5);

        // Flush with IF_ID_Write=1 still squashes.
        set_in(1, 1, 1, 0, 0, 0, 32'h0, 32'h55555555);
        edges(1);
        chk("flushw_valid", {31'b0, IF_ID_Valid}, 32'h0);
        chk("flushw_cnt", {16'b0, FlushCount}, 32'h2);

        // Address wrap.
        set_in(1, 1, 0, 0, 1, 0, 32'hFFFFFFFC, 32'h0);
        edges(1); chk("wrap_pre", PC_out, 32'hFFFFFFFC);
        set_in(1, 1, 0, 0, 0, 0, 32'h0, 32'h00000001);
        edges(1);
        chk("wrap_pc", PC_out, 32'h0);
        chk("wrap_pp4", IF_ID_PCPlus4, 32'h0);
        chk("wrap_valid", {31'b0, IF_ID_Valid}, 32'h1);

        // Reset pulse between edges with a redirect pending.
        set_in(1, 1, 0, 0, 1, 0, 32'h500, 32'h66666666);
        edges(1);
        chk("pend_pc", PC_out, 32'h500);
        #1 Reset_n = 1'b0;
        #1 chk_all_zero("async_rst");
        set_in(1, 1, 0, 0, 0, 0, 32'h0, 32'h77777777);
        #1 Reset_n = 1'b1;
        #1 chk("post_rst_pc", PC_out, 32'h0);
        edges(1);
        chk("post_rst_fetch", PC_out, 32'h4);
        chk("post_rst_pp4", IF_ID_PCPlus4, 32'h4);

        // Stall counter saturation.
        set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        edges(65534);
        chk("sat_fffe", {16'b0, StallCount}, 32'hFFFE);
        edges(1);
        chk("sat_ffff", {16'b0, StallCount}, 32'hFFFF);
        edges(1);
        chk("sat_hold", {16'b0, StallCount}, 32'hFFFF);
        chk("sat_pc", PC_out, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
